cnn_train_controller: RTL and testbench
=======================================

# cnn_train_controller

Parametrised training sequencer for the CNN datapath. It randomises conv kernels and fully-connected weights/bias from an external LFSR word, then runs a per-sample valid/ready loop: it waits a fixed settle window for the combinational forward/backward datapath, then issues a weight-commit pulse. It sits beside the conv → maxpool → flatten → FCL → softmax → cross-entropy chain and owns every parameter-register write strobe. It adds train/infer mode, re-initialisation, and sample/epoch accounting.

## Interface
- WIDTH, 16, fixed-point word width.
- CHANNELS, 10, number of conv kernels; this is the conv init row count.
- KERNEL_DIM, 3, kernel side length; KERNEL_DIM² ≤ FCL_OUTPUT_DIM is enforced by an elaboration-time check.
- FCL_INPUT_DIM, 4, FCL input count; the FCL init row count is FCL_INPUT_DIM+1 (the last row is bias).
- FCL_OUTPUT_DIM, 10, FCL output count; sets the rand_word width.
- SETTLE_CYCLES, 2, cycles (≥1) the datapath is given after a sample is accepted.
- SAMPLES_PER_EPOCH, 60000, samples per epoch (≥1).
- IDXW, $clog2(max(CHANNELS, FCL_INPUT_DIM+1)), param_idx width.
- clk, input, 1, the single clock.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, begins initialisation from IDLE.
- reinit, input, 1, returns from READY to initialisation.
- train_mode, input, 1, 1 = update weights, 0 = inference only; sampled on accept.
- rand_word, input, WIDTH*FCL_OUTPUT_DIM, LFSR output.
- sample_valid, input, 1, upstream has a sample presented.
- sample_ready, output, 1, controller will accept.
- param_we, output, 1, parameter row write strobe.
- param_sel, output, 1, 0 = conv kernel row, 1 = FCL weight row.
- param_idx, output, IDXW, row index.
- param_data, output, WIDTH*FCL_OUTPUT_DIM, registered copy of rand_word. For conv rows only the low KERNEL_DIM²·WIDTH bits are meaningful, in row-major order [j*KERNEL_DIM+k].
- commit, output, 1, one-cycle pulse telling consumers to latch the updated kernels and weights.
- result_valid, output, 1, one-cycle pulse; the datapath outputs are valid for this sample.
- init_done, output, 1, high while in READY, SETTLE or COMMIT.
- sample_count, output, 32, samples completed in the current epoch.
- epoch_count, output, 16, epochs completed; wraps.
- epoch_done, output, 1, one-cycle pulse on epoch boundary.

## Operation
States: IDLE, INIT_CONV, INIT_FCL, READY, SETTLE, COMMIT.

- **IDLE**
  - start=1 → INIT_CONV, with the row counter cleared.
  - All other inputs are ignored.
- **INIT_CONV**
  - Each cycle: param_we=1, param_sel=0, param_idx=counter, param_data=rand_word sampled that cycle.
  - Counter increments each cycle.
  - At counter CHANNELS-1 → INIT_FCL, with the counter cleared.
- **INIT_FCL**
  - Same as INIT_CONV but with param_sel=1.
  - Runs exactly FCL_INPUT_DIM+1 rows, indices 0..FCL_INPUT_DIM; the bias row is index FCL_INPUT_DIM.
  - After the last row → READY.
- **READY**
  - sample_ready=1.
  - reinit=1 has priority over sample_valid → INIT_CONV, with the counter cleared; sample_count and epoch_count are cleared.
  - Otherwise sample_valid=1 is an accept: train_mode is latched and the state goes to SETTLE with the settle counter at 0.
- **SETTLE**
  - sample_ready=0.
  - Lasts exactly SETTLE_CYCLES cycles, then → COMMIT.
- **COMMIT** (one cycle)
  - result_valid=1.
  - commit=1 only if the latched train_mode=1.
  - sample_count increments.
  - If sample_count was SAMPLES_PER_EPOCH-1: sample_count becomes 0, epoch_count increments (wrapping at 2¹⁶), and epoch_done=1.
  - Next state → READY.
- start outside IDLE, and reinit outside READY, are ignored.
- No arithmetic is performed on the data; param_data is a bit-exact copy of rand_word.

## Timing
- Every output is a registered Moore output decoded from state and counters.
- **Reset values:** state IDLE; every output 0, including param_data, sample_count and epoch_count.
- **Asynchronous reset mid-operation:** everything returns to the reset values immediately.
  - A partial initialisation is abandoned; start must be issued again.
  - A sample in SETTLE is dropped: no commit and no result_valid.
- **Initialisation:**
  - start is sampled at edge 0.
  - param_we is high for cycles 1 … CHANNELS+FCL_INPUT_DIM+1 inclusive, contiguous with no gaps.
  - sample_ready and init_done rise in the following cycle.
- **Sample latency:**
  - Accept edge at cycle t; SETTLE occupies t+1 … t+SETTLE_CYCLES.
  - commit/result_valid are high in cycle t+SETTLE_CYCLES+1.
  - sample_ready is high again at t+SETTLE_CYCLES+2.
  - Throughput is one sample per SETTLE_CYCLES+2 cycles.
- **Handshake:**
  - An accept happens only on a cycle with sample_valid && sample_ready.
  - sample_valid held high while not ready is not consumed and needs no drop.
  - sample_ready never depends combinationally on sample_valid.
- **Simultaneous events:**
  - reinit and sample_valid in READY: reinit wins, and no sample is accepted.
  - A change to train_mode during SETTLE does not affect the pending commit.

## Test plan
- **Init sequence:** CHANNELS=10, FCL_INPUT_DIM=4, reset then start pulse. Expect param_we high for 15 consecutive cycles: sel=0 with idx 0..9, then sel=1 with idx 0..4; param_data equals rand_word of the prior cycle; init_done rises the cycle after.
- **Train sample:** SETTLE_CYCLES=2, train_mode=1, sample_valid at accept edge t. Expect sample_ready low for t+1..t+3; commit and result_valid high only at t+3; sample_count=1.
- **Infer sample:** train_mode=0 at accept, toggled to 1 during SETTLE. Expect result_valid pulse, commit stays 0, sample_count increments.
- **Epoch wrap:** SAMPLES_PER_EPOCH=3, stream 7 samples back-to-back. Expect epoch_done pulses on samples 3 and 6; final sample_count=1, epoch_count=2.
- **Priority:** assert reinit and sample_valid together in READY. Expect no accept, init rewrite of 15 rows, counts cleared.
- **Reset mid-op:** reset during INIT_FCL row 2, and separately during SETTLE. Expect all outputs 0 immediately, no commit, state IDLE until start.

Source files
------------

// File: rtl/cnn_train_if.sv
// Handshake and parameter-bus bundle between the training controller and its
// environment (LFSR, sample source, parameter register file, datapath consumers).
interface cnn_train_if #(
    parameter int WIDTH          = 16,
    parameter int FCL_OUTPUT_DIM = 10,
    parameter int IDXW           = 4
);
    logic                            start;
    logic                            reinit;
    logic                            train_mode;
    logic [WIDTH*FCL_OUTPUT_DIM-1:0] rand_word;
    logic                            sample_valid;
    logic                            sample_ready;
    logic                            param_we;
    logic                            param_sel;
    logic [IDXW-1:0]                 param_idx;
    logic [WIDTH*FCL_OUTPUT_DIM-1:0] param_data;
    logic                            commit;
    logic                            result_valid;
    logic                            init_done;
    logic [31:0]                     sample_count;
    logic [15:0]                     epoch_count;
    logic                            epoch_done;

    modport master (
        output start, reinit, train_mode, rand_word, sample_valid,
        input  sample_ready, param_we, param_sel, param_idx, param_data,
               commit, result_valid, init_done, sample_count, epoch_count, epoch_done
    );

    modport slave (
        input  start, reinit, train_mode, rand_word, sample_valid,
        output sample_ready, param_we, param_sel, param_idx, param_data,
               commit, result_valid, init_done, sample_count, epoch_count, epoch_done
    );
endinterface

// File: rtl/cnn_train_controller.sv
// Training sequencer: writes random initial conv/FCL parameter rows, then runs the
// per-sample accept / settle / commit loop with sample and epoch accounting.
module cnn_train_controller #(
    parameter int WIDTH             = 16,
    parameter int CHANNELS          = 10,
    parameter int KERNEL_DIM        = 3,
    parameter int FCL_INPUT_DIM     = 4,
    parameter int FCL_OUTPUT_DIM    = 10,
    parameter int SETTLE_CYCLES     = 2,
    parameter int SAMPLES_PER_EPOCH = 60000,
    parameter int IDXW = $clog2((CHANNELS > FCL_INPUT_DIM + 1) ? CHANNELS : FCL_INPUT_DIM + 1)
) (
    input  logic       clk,
    input  logic       reset,
    cnn_train_if.slave bus
);
    localparam int DW = WIDTH * FCL_OUTPUT_DIM;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    if (KERNEL_DIM * KERNEL_DIM > FCL_OUTPUT_DIM) begin : g_kernel_fit_check
        $error("KERNEL_DIM squared must not exceed FCL_OUTPUT_DIM");
    end

    typedef enum logic [2:0] {IDLE, INIT_CONV, INIT_FCL, READY, SETTLE, COMMIT} state_t;

    state_t          state_r, nxt_state_s;
    logic [IDXW-1:0] row_r, nxt_row_s;
    logic [SW-1:0]   settle_r, nxt_settle_s;
    logic            mode_r, nxt_mode_s;
    logic [31:0]     scount_r, nxt_scount_s;
    logic [15:0]     ecount_r, nxt_ecount_s;
    logic            nxt_edone_s;
    logic            nxt_init_s;

    logic            param_we_r, param_sel_r, sample_ready_r, commit_r;
    logic            result_valid_r, init_done_r, epoch_done_r;
    logic [IDXW-1:0] param_idx_r;
    logic [DW-1:0]   param_data_r;

    // Next-state, counter and accounting decode
    always_comb begin
        nxt_state_s  = state_r;
        nxt_row_s    = row_r;
        nxt_settle_s = settle_r;
        nxt_mode_s   = mode_r;
        nxt_scount_s = scount_r;
        nxt_ecount_s = ecount_r;
        nxt_edone_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    nxt_state_s = INIT_CONV;
                    nxt_row_s   = '0;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            INIT_CONV: begin
                if (row_r == IDXW'(CHANNELS - 1)) begin
                    nxt_state_s = INIT_FCL;
                    nxt_row_s   = '0;
                end else begin
                    nxt_row_s = row_r + IDXW'(1);
                end
            end
            INIT_FCL: begin
                // Last row (index FCL_INPUT_DIM) is the bias row
                if (row_r == IDXW'(FCL_INPUT_DIM)) begin
                    nxt_state_s = READY;
                    nxt_row_s   = '0;
                end else begin
                    nxt_row_s = row_r + IDXW'(1);
                end
            end
            READY: begin
                if (bus.reinit) begin
                    nxt_state_s  = INIT_CONV;
                    nxt_row_s    = '0;
                    nxt_scount_s = 32'd0;
                    nxt_ecount_s = 16'd0;
                end else if (bus.sample_valid) begin
                    nxt_state_s  = SETTLE;
                    nxt_settle_s = '0;
                    nxt_mode_s   = bus.train_mode;
                end else begin
                    nxt_state_s = READY;
                end
            end
            SETTLE: begin
                if (settle_r == SW'(SETTLE_CYCLES - 1)) begin
                    nxt_state_s = COMMIT;
                    if (scount_r == 32'(SAMPLES_PER_EPOCH - 1)) begin
                        nxt_scount_s = 32'd0;
                        nxt_ecount_s = ecount_r + 16'd1;
                        nxt_edone_s  = 1'b1;
                    end else begin
                        nxt_scount_s = scount_r + 32'd1;
                    end
                end else begin
                    nxt_settle_s = settle_r + SW'(1);
                end
            end
            COMMIT: begin
                nxt_state_s = READY;
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase
        nxt_init_s = (nxt_state_s == INIT_CONV) || (nxt_state_s == INIT_FCL);
    end

    // State, counters and registered Moore outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            row_r          <= '0;
            settle_r       <= '0;
            mode_r         <= 1'b0;
            scount_r       <= 32'd0;
            ecount_r       <= 16'd0;
            param_we_r     <= 1'b0;
            param_sel_r    <= 1'b0;
            param_idx_r    <= '0;
            param_data_r   <= '0;
            sample_ready_r <= 1'b0;
            commit_r       <= 1'b0;
            result_valid_r <= 1'b0;
            init_done_r    <= 1'b0;
            epoch_done_r   <= 1'b0;
        end else begin
            state_r        <= nxt_state_s;
            row_r          <= nxt_row_s;
            settle_r       <= nxt_settle_s;
            mode_r         <= nxt_mode_s;
            scount_r       <= nxt_scount_s;
            ecount_r       <= nxt_ecount_s;
            param_we_r     <= nxt_init_s;
            param_sel_r    <= (nxt_state_s == INIT_FCL);
            param_idx_r    <= nxt_init_s ? nxt_row_s : '0;
            param_data_r   <= nxt_init_s ? bus.rand_word : param_data_r;
            sample_ready_r <= (nxt_state_s == READY);
            commit_r       <= (nxt_state_s == COMMIT) && nxt_mode_s;
            result_valid_r <= (nxt_state_s == COMMIT);
            init_done_r    <= (nxt_state_s == READY) || (nxt_state_s == SETTLE) ||
                              (nxt_state_s == COMMIT);
            epoch_done_r   <= nxt_edone_s;
        end
    end

    assign bus.param_we     = param_we_r;
    assign bus.param_sel    = param_sel_r;
    assign bus.param_idx    = param_idx_r;
    assign bus.param_data   = param_data_r;
    assign bus.sample_ready = sample_ready_r;
    assign bus.commit       = commit_r;
    assign bus.result_valid = result_valid_r;
    assign bus.init_done    = init_done_r;
    assign bus.sample_count = scount_r;
    assign bus.epoch_count  = ecount_r;
    assign bus.epoch_done   = epoch_done_r;
endmodule

// File: tb/tb_cnn_train_controller.sv
// Bench for cnn_train_controller: init-sequence vector table, hand-written corner
// sequences and a randomized run, all checked against a cycle-timeline model.
module tb_cnn_train_controller;
    localparam int WIDTH = 16;
    localparam int FOD   = 10;
    localparam int CH    = 10;
    localparam int KD    = 3;
    localparam int FID   = 4;
    localparam int S     = 2;
    localparam int SPE   = 3;
    localparam int IDXW  = 4;
    localparam int DW    = WIDTH * FOD;
    localparam int ROWS  = CH + FID + 1;

    logic clk = 1'b0;
    logic reset;

    cnn_train_if #(.WIDTH(WIDTH), .FCL_OUTPUT_DIM(FOD), .IDXW(IDXW)) bus ();

    cnn_train_controller #(
        .WIDTH(WIDTH), .CHANNELS(CH), .KERNEL_DIM(KD), .FCL_INPUT_DIM(FID),
        .FCL_OUTPUT_DIM(FOD), .SETTLE_CYCLES(S), .SAMPLES_PER_EPOCH(SPE), .IDXW(IDXW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Timeline model: events are placed on absolute cycle numbers
    int            cyc;
    bit            idle;
    int            init_lo;
    int            ready_at;
    bit            pend;
    int            pend_cyc;
    bit            pend_mode;
    int            scount;
    int            ecount;
    logic [DW-1:0] prev_rw;
    int            edone_seen;

    typedef struct {
        logic [DW-1:0]   rw;
        logic            we;
        logic            sel;
        logic [IDXW-1:0] idx;
        logic            rdy;
    } vec_t;
    vec_t tab [ROWS + 2];

    function automatic logic [DW-1:0] rand_word_f();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        idle     = 1'b1;
        pend     = 1'b0;
        scount   = 0;
        ecount   = 0;
        init_lo  = -1000;
        ready_at = 1 << 30;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"},     bus.param_we, 0);
        chk({tag, "_sel"},    bus.param_sel, 0);
        chk({tag, "_idx"},    bus.param_idx, 0);
        chk({tag, "_data"},   bus.param_data, 0);
        chk({tag, "_ready"},  bus.sample_ready, 0);
        chk({tag, "_commit"}, bus.commit, 0);
        chk({tag, "_rv"},     bus.result_valid, 0);
        chk({tag, "_idone"},  bus.init_done, 0);
        chk({tag, "_scnt"},   bus.sample_count, 0);
        chk({tag, "_ecnt"},   bus.epoch_count, 0);
        chk({tag, "_edone"},  bus.epoch_done, 0);
    endtask

    task automatic check_outputs();
        bit e_we, e_rdy, e_done, e_rv, e_cm, e_ed;
        int row;
        e_we   = !idle && cyc >= init_lo && cyc < init_lo + ROWS;
        e_rdy  = !idle && cyc >= ready_at;
        e_done = !idle && cyc >= init_lo + ROWS;
        e_rv   = pend && cyc == pend_cyc;
        e_cm   = e_rv && pend_mode;
        e_ed   = 1'b0;
        if (e_rv) begin
            pend = 1'b0;
            scount++;
            if (scount == SPE) begin
                scount = 0;
                ecount = (ecount + 1) % 65536;
                e_ed   = 1'b1;
            end
        end
        chk("param_we", bus.param_we, e_we);
        chk("sample_ready", bus.sample_ready, e_rdy);
        chk("init_done", bus.init_done, e_done);
        chk("result_valid", bus.result_valid, e_rv);
        chk("commit", bus.commit, e_cm);
        chk("epoch_done", bus.epoch_done, e_ed);
        if (e_we) begin
            row = cyc - init_lo;
            chk("param_sel", bus.param_sel, row >= CH);
            chk("param_idx", bus.param_idx, (row >= CH) ? row - CH : row);
            chk("param_data", bus.param_data, prev_rw);
        end
        if (e_rdy) begin
            chk("sample_count", bus.sample_count, scount);
            chk("epoch_count", bus.epoch_count, ecount);
        end
    endtask

    // Apply the rules for what the coming edge does to the timeline
    task automatic model_edge(input bit st, input bit v, input bit m, input bit ri);
        if (idle) begin
            if (st) begin
                idle     = 1'b0;
                init_lo  = cyc + 1;
                ready_at = cyc + 1 + ROWS;
            end
        end else if (cyc >= ready_at) begin
            if (ri) begin
                init_lo  = cyc + 1;
                ready_at = cyc + 1 + ROWS;
                scount   = 0;
                ecount   = 0;
            end else if (v) begin
                pend      = 1'b1;
                pend_cyc  = cyc + S + 1;
                pend_mode = m;
                ready_at  = cyc + S + 2;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit v, input bit m, input bit ri,
                         input logic [DW-1:0] rw);
        check_outputs();
        bus.start        = st;
        bus.sample_valid = v;
        bus.train_mode   = m;
        bus.reinit       = ri;
        bus.rand_word    = rw;
        model_edge(st, v, m, ri);
        prev_rw = rw;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rand_word_f());
    endtask

    task automatic reset_midop(input string tag);
        #2 reset = 1'b1;
        #1;
        chk_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.reinit       = 1'b0;
        bus.train_mode   = 1'b0;
        bus.sample_valid = 1'b0;
        bus.rand_word    = '0;
        prev_rw          = '0;
        reset            = 1'b1;
        cyc              = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        reset = 1'b0;

        // Inputs other than start are ignored in IDLE
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, rand_word_f());

        // Init sequence vector table: row i holds the word driven in cycle i and
        // the outputs expected one cycle later
        for (int i = 0; i < ROWS + 2; i++) begin
            tab[i].rw  = rand_word_f();
            tab[i].we  = (i < ROWS);
            tab[i].sel = (i >= CH) && (i < ROWS);
            tab[i].idx = (i < CH) ? IDXW'(i) : ((i < ROWS) ? IDXW'(i - CH) : '0);
            tab[i].rdy = (i == ROWS);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, tab[0].rw);
        for (int i = 0; i <= ROWS; i++) begin
            chk("tab_we", bus.param_we, tab[i].we);
            chk("tab_ready", bus.sample_ready, tab[i].rdy);
            chk("tab_init_done", bus.init_done, tab[i].rdy);
            if (tab[i].we) begin
                chk("tab_sel", bus.param_sel, tab[i].sel);
                chk("tab_idx", bus.param_idx, tab[i].idx);
                chk("tab_data", bus.param_data, tab[i].rw);
            end
            cycle(1'b0, 1'b0, 1'b0, 1'b0, tab[i+1].rw);
        end

        // Train sample
        cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word_f());
        chk("train_t1_ready", bus.sample_ready, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, rand_word_f());
        chk("train_t2_commit", bus.commit, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, rand_word_f());
        chk("train_t3_commit", bus.commit, 1);
        chk("train_t3_rv", bus.result_valid, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, rand_word_f());
        chk("train_count", bus.sample_count, 1);

        // Infer sample, mode flipped and valid held during SETTLE
        cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_word_f());
        cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word_f());
        cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word_f());
        chk("infer_rv", bus.result_valid, 1);
        chk("infer_commit", bus.commit, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, rand_word_f());
        chk("infer_count", bus.sample_count, 2);

        // reinit beats sample_valid
        cycle(1'b0, 1'b1, 1'b1, 1'b1, rand_word_f());
        chk("prio_we", bus.param_we, 1);
        chk("prio_ready", bus.sample_ready, 0);
        idle_cycles(ROWS);
        chk("prio_ready_back", bus.sample_ready, 1);
        chk("prio_scount", bus.sample_count, 0);
        chk("prio_ecount", bus.epoch_count, 0);

        // Epoch wrap: 7 back-to-back samples
        edone_seen = 0;
        for (int i = 0; i < 7 * (S + 2); i++) begin
            if (bus.epoch_done === 1'b1) edone_seen++;
            cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word_f());
        end
        chk("wrap_edone_pulses", edone_seen, 2);
        chk("wrap_scount", bus.sample_count, 1);
        chk("wrap_ecount", bus.epoch_count, 2);

        // Reset while a sample is in SETTLE: no commit afterwards
        cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word_f());
        reset_midop("rst_settle");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, rand_word_f());

        // Reset during FCL row 2
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_word_f());
        idle_cycles(CH + 2);
        chk("fcl2_sel", bus.param_sel, 1);
        chk("fcl2_idx", bus.param_idx, 2);
        reset_midop("rst_fcl");
        idle_cycles(4);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_word_f());
        idle_cycles(ROWS + 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0), rand_word_f());
        end
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
